// File: rtl/jk_pkg.sv
// JK command encodings and the excitation helper shared by the counter and its cells.
package jk_pkg;

    // {J,K} command applied to one JK storage cell
    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_cmd_e;

    // Command that takes a cell from its current bit to the next bit while counting.
    // A changing bit toggles and a stable bit holds.
    function automatic jk_cmd_e jk_excite(input logic cur, input logic nxt);
        if (cur == nxt) begin
            return JK_HOLD;
        end
        return JK_TOGGLE;
    endfunction

    // Command that forces a cell to a fixed value regardless of its current state
    function automatic jk_cmd_e jk_force(input logic val);
        return val ? JK_SET : JK_RESET;
    endfunction

endpackage

// File: rtl/jk_ff.sv
// Single edge-triggered JK storage cell with synchronous active-high reset to 0.
module jk_ff (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic nq
);

    // JK state update: hold / reset / set / toggle
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b00:   q <= q;
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                default: q <= ~q;
            endcase
        end
    end

    assign nq = ~q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MOD up/down counter built from WIDTH JK cells. This block only computes the
// per-bit J/K commands; the cells hold the state. Priority per edge: rst > load > en > hold.
// Optional macro JK_MOD_COUNTER_SAT_EN: saturate at 0 / MOD-1 instead of wrapping
// (wrap tied low, tc unchanged).
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_mod
        $error("jk_mod_counter: MOD out of range 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 1);

    logic [WIDTH-1:0]      nq;
    logic [WIDTH-1:0]      q_next;
    logic [WIDTH-1:0]      din_clamp;
    logic [WIDTH-1:0][1:0] cmd;
    logic                  at_max;
    logic                  at_zero;
    logic                  wrap_next;

    // The inverted cell outputs give the zero detect directly
    assign at_zero = &nq;
    assign at_max  = (q == MAX_Q);

    // Terminal count is combinational so a following digit can enable in the same cycle
    assign tc = en & (up ? at_max : at_zero);

    // Load values at or above MOD clamp to the top of the count range
    assign din_clamp = (int'(din) >= MOD) ? MAX_Q : din;

    // Next count value and wrap flag for an enabled step
    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        if (int'(q) >= MOD) begin
            q_next = '0;
        end else if (up) begin
            if (at_max) begin
`ifdef JK_MOD_COUNTER_SAT_EN
                q_next = q;
`else
                q_next    = '0;
                wrap_next = 1'b1;
`endif
            end else begin
                q_next = q + WIDTH'(1);
            end
        end else begin
            if (at_zero) begin
`ifdef JK_MOD_COUNTER_SAT_EN
                q_next = q;
`else
                q_next    = MAX_Q;
                wrap_next = 1'b1;
`endif
            end else begin
                q_next = q - WIDTH'(1);
            end
        end
    end

    // Per-bit J/K excitation following the rst > load > en > hold priority
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            cmd[i] = JK_HOLD;
        end
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                cmd[i] = JK_RESET;
            end
        end else if (load) begin
            for (int i = 0; i < WIDTH; i++) begin
                cmd[i] = jk_force(din_clamp[i]);
            end
        end else if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                cmd[i] = jk_excite(q[i], q_next[i]);
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_ff u_cell (
            .clk (clk),
            .rst (rst),
            .j   (cmd[g][1]),
            .k   (cmd[g][0]),
            .q   (q[g]),
            .nq  (nq[g])
        );
    end

    // One-cycle wrap pulse aligned with the cycle q shows the wrapped value
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap <= 1'b0;
        end else begin
            wrap <= ~load & en & wrap_next;
        end
    end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed self-checking bench for jk_mod_counter (WIDTH=4, MOD=10).
module tb_jk_mod_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] din;
    logic [3:0] q;
    logic       tc;
    logic       wrap;

    int checks   = 0;
    int failures = 0;

    jk_mod_counter #(.WIDTH(4), .MOD(10)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .up   (up),
        .load (load),
        .din  (din),
        .q    (q),
        .tc   (tc),
        .wrap (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int eq, input int ewrap, input int etc);
        check({tag, "_q"}, int'(q), eq);
        check({tag, "_wrap"}, int'(wrap), ewrap);
        check({tag, "_tc"}, int'(tc), etc);
    endtask

    initial begin
        int up_q[12]    = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        int up_wrap[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        int up_tc[12]   = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
`ifdef JK_MOD_COUNTER_SAT_EN
        int top_q[4]    = '{9, 9, 9, 9};
        int top_wrap[4] = '{0, 0, 0, 0};
        int top_tc[4]   = '{1, 1, 1, 1};
        int after_dn    = 8;
        int dn_q0       = 0;
        int dn_wrap0    = 0;
        int dn_tc0      = 1;
`else
        int top_q[4]    = '{9, 0, 1, 2};
        int top_wrap[4] = '{0, 1, 0, 0};
        int top_tc[4]   = '{1, 0, 0, 0};
        int after_dn    = 1;
        int dn_q0       = 9;
        int dn_wrap0    = 1;
        int dn_tc0      = 0;
`endif

        rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b1; din = 4'd7;

        // reset dominates load and enable
        step();
        check_out("rst_edge1", 0, 0, 0);
        step();
        check_out("rst_edge2", 0, 0, 0);
        up = 1'b0;
        #1;
        check("rst_tc_down", int'(tc), 1);

        // count up across the modulus
        rst = 1'b0; load = 1'b0; up = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check_out($sformatf("up%0d", i), up_q[i], up_wrap[i], up_tc[i]);
        end

        // back to zero, then count down through the wrap
        load = 1'b1; din = 4'd0;
        step();
        check_out("load0", 0, 0, 0);
        load = 1'b0; up = 1'b0;
        #1;
        check("down_tc_at0", int'(tc), 1);
        step();
        check_out("down_wrap", dn_q0, dn_wrap0, dn_tc0);
`ifndef JK_MOD_COUNTER_SAT_EN
        step();
        check_out("down8", 8, 0, 0);
        step();
        check_out("down7", 7, 0, 0);
`endif

        // load clamp, plain load, then hold
        load = 1'b1; en = 1'b1; up = 1'b1; din = 4'd12;
        step();
        check_out("load_clamp", 9, 0, 1);
        din = 4'd5;
        step();
        check_out("load5", 5, 0, 0);
        load = 1'b0; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out($sformatf("hold%0d", i), 5, 0, 0);
        end

        // load wins over a wrapping step
        load = 1'b1; din = 4'd9;
        step();
        load = 1'b0; en = 1'b1; up = 1'b1;
        #1;
        check("tc_at9", int'(tc), 1);
        load = 1'b1; din = 4'd2;
        step();
        check_out("load_over_wrap", 2, 0, 0);

        // reset mid-count overrides load
        din = 4'd3;
        step();
        load = 1'b0;
        step();
        check("count_to4", int'(q), 4);
        rst = 1'b1; load = 1'b1; din = 4'd3;
        step();
        check_out("rst_over_load", 0, 0, 0);
        rst = 1'b0; load = 1'b0;
        step();
        check_out("resume", 1, 0, 0);

        // behaviour at the top of the range (saturate or wrap)
        load = 1'b1; din = 4'd8;
        step();
        load = 1'b0; up = 1'b1; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_out($sformatf("top%0d", i), top_q[i], top_wrap[i], top_tc[i]);
        end
        up = 1'b0;
        step();
        check("top_down", int'(q), after_dn);
        check("top_down_wrap", int'(wrap), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
- Synchronous modulo-MOD up/down counter. Each state bit is stored in a JK flip-flop cell.
- The block's main job is J/K excitation logic: it computes per-bit J/K commands (hold/reset/set/toggle) that drive the storage cells.
- It is the stage that sits directly upstream of the JK storage elements and feeds them.
- Used as a BCD/decade digit, or cascaded via tc/wrap into multi-digit counters.

Parameters:
- WIDTH, 4, number of counter bits / JK cells.
- MOD, 10, count modulus; legal range 2..2**WIDTH; elaboration error outside range.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  count enable; one step per clk edge while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load of din.
- din  input  WIDTH  load value.
- q  output  WIDTH  counter state (direct JK cell outputs).
- tc  output  1  terminal count, combinational: q==MOD-1 when up=1; q==0 when up=0; gated by en.
- wrap  output  1  registered one-cycle pulse on the edge where q wraps.

Behaviour:
- Single clock domain. clk and rst are decided: one clock; reset synchronous and active-high.
- Priority per edge: rst > load > en > hold.
- rst=1 at edge: q=0, wrap=0. All cells are driven with J=0, K=1. rst mid-count overrides load/en that cycle.
- load=1 (rst=0):
  - Bit i gets J=din[i], K=~din[i]; q=din next cycle. en and up are ignored.
  - din>=MOD: q=MOD-1 (clamped).
  - wrap=0.
- en=1, up=1:
  - q<MOD-1: q+1.
  - q==MOD-1: q=0 and wrap=1 on the following cycle.
- en=1, up=0:
  - q>0: q-1.
  - q==0: q=MOD-1 and wrap=1.
- en=0: every cell J=K=0; q holds; wrap=0.
- Excitation rule: every state change is expressed only through J/K per bit. Toggle bits use J=K=1. Bits forced to a value use a set/reset command. Bits not changing use hold. No direct register writes of q.
- wrap is high exactly one cycle, aligned with the cycle q shows the wrapped value. Back-to-back wraps are possible when MOD=2 (wrap high on consecutive cycles).
- tc is combinational from q, up and en, so an external cascade counter enables on tc in the same cycle.
- Latency: one cycle from input edge to q/wrap update. No output pipelining.
- Out-of-range state (q>=MOD), unreachable except from X: the next enabled step forces q=0.
- Outputs after reset: q=0, wrap=0, tc=(en&~up).

Optional Feature:
- Macro: JK_MOD_COUNTER_SAT_EN.
- Defined:
  - Saturating mode. up at MOD-1 holds at MOD-1; down at 0 holds at 0.
  - wrap is never asserted (tied 0); tc is unchanged.
  - Excitation is hold for all bits at the saturation point.
- Undefined: modulo wrap as described above.

Decomposition:
- Package jk_pkg:
  - JK command encodings as 2-bit {J,K} constants: JK_HOLD=00, JK_RESET=01, JK_SET=10, JK_TOGGLE=11.
  - Helper function mapping (current bit, next bit) to JK command.
- Sub-module jk_ff:
  - One edge-triggered JK cell: clk, rst, j, k -> q, nq.
  - Synchronous active-high reset to 0.
  - Instantiated WIDTH times via generate.
- Top block: next-state calculation, load clamp, excitation mapping, wrap register, tc logic.

Test Plan:
- rst=1 for 2 cycles with en=1, load=1, din=7 -> q=0, wrap=0 after each edge.
- en=1, up=1 from 0 for 12 edges -> q=1..9,0,1,2; wrap high only on the cycle q=0 (after the 10th edge); tc high when q=9.
- en=1, up=0 from q=0 -> q=9, wrap=1 for one cycle; then 8, 7 with wrap=0.
- load=1, din=12, en=1 -> q=9 (clamp). Then load=1, din=5 -> q=5. Then load=0, en=0 for 3 cycles -> q stays 5, wrap=0.
- q=4 counting up with rst asserted in the same cycle as load=1, din=3 -> q=0; resume en=1 -> 1.
- JK_MOD_COUNTER_SAT_EN defined, up=1 from 8 for 4 edges -> q=9,9,9,9, wrap=0. Then up=0 -> 8.
